// File: rtl/word_sel_seq.sv
// N:1 word selector with a registered valid/ready output slot.
// Direct mode muxes one channel per cycle; stream mode snapshots all channels and emits them in order.
module word_sel_seq #(
  parameter  int DW  = 32,
  parameter  int NCH = 8,
  localparam int SW  = $clog2(NCH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mode_i,
  input  logic [SW-1:0]     sel_i,
  input  logic [NCH*DW-1:0] din_i,
  input  logic              start_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DW-1:0]     dout_o,
  output logic [SW-1:0]     idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [SW:0] NCH_W = (SW+1)'(NCH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  snap_q [NCH];
  logic [DW-1:0]  snap_d [NCH];
  logic [DW-1:0]  din_ch [NCH];
  logic [SW:0]    cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic [SW-1:0]  idx_q, idx_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           slot_free;

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      din_ch[k] = din_i[k*DW +: DW];
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    dout_d    = dout_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    slot_free = !valid_q || ready_i;

    unique case (state_q)
      IDLE: begin
        if (mode_i) begin
          if (start_i) begin
            // Start discards any pending direct word even under backpressure.
            snap_d  = din_ch;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = STREAM;
          end else if (slot_free) begin
            valid_d = 1'b0;
          end
        end else if (slot_free) begin
          if ({1'b0, sel_i} < NCH_W) begin
            dout_d  = din_ch[sel_i];
            idx_d   = sel_i;
            valid_d = 1'b1;
          end else begin
            dout_d  = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      STREAM: begin
        if (slot_free) begin
          if (cnt_q < NCH_W) begin
            dout_d  = snap_q[cnt_q[SW-1:0]];
            idx_d   = cnt_q[SW-1:0];
            valid_d = 1'b1;
            cnt_d   = cnt_q + (SW+1)'(1);
          end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      for (int unsigned k = 0; k < NCH; k++) begin
        snap_q[k] <= '0;
      end
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign dout_o  = dout_q;
  assign idx_o   = idx_q;
  assign busy_o  = (state_q == STREAM);
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_word_sel_seq.sv
// Scoreboard bench for word_sel_seq: an NCH=8 and an NCH=5 instance, with expected words queued at
// stimulus time and popped by per-instance monitors on each accepted transfer.
module tb_word_sel_seq;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  exp_t q8[$];
  exp_t q5[$];

  // NCH=8 instance
  logic         rst8, mode8, start8, ready8;
  logic [2:0]   sel8;
  logic [255:0] din8;
  logic         valid8, busy8, done8, err8;
  logic [31:0]  dout8;
  logic [2:0]   idx8;

  // NCH=5 instance
  logic         rst5, mode5, start5, ready5;
  logic [2:0]   sel5;
  logic [159:0] din5;
  logic         valid5, busy5, done5, err5;
  logic [31:0]  dout5;
  logic [2:0]   idx5;

  word_sel_seq #(.DW(32), .NCH(8)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst8), .mode_i(mode8), .sel_i(sel8), .din_i(din8),
    .start_i(start8), .ready_i(ready8), .valid_o(valid8), .dout_o(dout8),
    .idx_o(idx8), .busy_o(busy8), .done_o(done8), .err_o(err8)
  );

  word_sel_seq #(.DW(32), .NCH(5)) u_dut5 (
    .clk_i(clk), .rst_n_i(rst5), .mode_i(mode5), .sel_i(sel5), .din_i(din5),
    .start_i(start5), .ready_i(ready5), .valid_o(valid5), .dout_o(dout5),
    .idx_o(idx5), .busy_o(busy5), .done_o(done5), .err_o(err5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [31:0] d, input int i);
    exp_t e;
    e.data = d;
    e.idx  = 4'(i);
    q8.push_back(e);
  endtask

  task automatic push5(input logic [31:0] d, input int i);
    exp_t e;
    e.data = d;
    e.idx  = 4'(i);
    q5.push_back(e);
  endtask

  // A transfer happens at the next rising edge when valid and ready are both high now.
  always @(negedge clk) begin
    if (rst8 && valid8 && ready8) begin
      if (q8.size() == 0) chk("u8_unexpected_word", {29'd0, idx8}, 64'hFFFF);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("u8_dout", dout8, e.data);
        chk("u8_idx", idx8, e.idx);
      end
    end
    if (rst5 && valid5 && ready5) begin
      if (q5.size() == 0) chk("u5_unexpected_word", {29'd0, idx5}, 64'hFFFF);
      else begin
        exp_t e;
        e = q5.pop_front();
        chk("u5_dout", dout5, e.data);
        chk("u5_idx", idx5, e.idx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_cnt;
    logic [3:0] pat;
    pat = 4'b1001;

    // Reset with random inputs on both instances
    rst8 = 1'b0; rst5 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mode8 = 1'($urandom); start8 = 1'($urandom); ready8 = 1'($urandom); sel8 = 3'($urandom);
      mode5 = 1'($urandom); start5 = 1'($urandom); ready5 = 1'($urandom); sel5 = 3'($urandom);
      for (int k = 0; k < 8; k++) din8[k*32 +: 32] = $urandom;
      for (int k = 0; k < 5; k++) din5[k*32 +: 32] = $urandom;
      tick();
    end
    chk("rst8_outputs", {valid8, dout8, idx8, busy8, done8, err8}, 64'd0);
    chk("rst5_outputs", {valid5, dout5, idx5, busy5, done5, err5}, 64'd0);
    rst8 = 1'b1; rst5 = 1'b1;
    mode8 = 1'b1; start8 = 1'b0; ready8 = 1'b0; sel8 = '0;
    mode5 = 1'b1; start5 = 1'b0; ready5 = 1'b0; sel5 = '0;
    tick();
    chk("idle8_outputs", {valid8, dout8, idx8, busy8, done8, err8}, 64'd0);
    chk("idle5_outputs", {valid5, dout5, idx5, busy5, done5, err5}, 64'd0);

    // Direct sweep with ready held high
    for (int k = 0; k < 8; k++) din8[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
    mode8 = 1'b0; ready8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sel8 = 3'(k);
      push8(32'hA5A5_0000 + 32'(k), k);
      tick();
      chk("direct_valid", valid8, 1);
    end
    mode8 = 1'b1; start8 = 1'b0;
    tick();
    chk("drain_valid", valid8, 0);

    // Direct backpressure
    mode8 = 1'b0; sel8 = 3'd3; ready8 = 1'b0;
    push8(32'hA5A5_0003, 3);
    tick();
    chk("bp_load_dout", dout8, 32'hA5A5_0003);
    sel8 = 3'd5;
    tick(); tick();
    chk("bp_hold_dout", dout8, 32'hA5A5_0003);
    chk("bp_hold_idx", idx8, 3);
    ready8 = 1'b1;
    push8(32'hA5A5_0005, 5);
    tick();
    chk("bp_release_dout", dout8, 32'hA5A5_0005);
    mode8 = 1'b1; start8 = 1'b0;
    tick();
    chk("bp_drain_valid", valid8, 0);

    // Stream with ready high; inputs change right after start is sampled
    for (int k = 0; k < 8; k++) begin
      din8[k*32 +: 32] = 32'h5000_0000 + 32'(k);
      push8(32'h5000_0000 + 32'(k), k);
    end
    mode8 = 1'b1; start8 = 1'b1; ready8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) din8[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
    chk("stream_busy", busy8, 1);
    chk("stream_valid_after_start", valid8, 0);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (done8) break;
    end
    chk("stream_done_cycle", n, 9);
    chk("stream_end_busy", busy8, 0);
    chk("stream_end_valid", valid8, 0);
    tick();
    chk("stream_done_pulse", done8, 0);
    chk("stream_q_empty", q8.size(), 0);

    // Stream under backpressure with a spurious mid-stream start
    for (int k = 0; k < 8; k++) begin
      din8[k*32 +: 32] = 32'h7700_0000 + 32'(k);
      push8(32'h7700_0000 + 32'(k), k);
    end
    start8 = 1'b1; ready8 = 1'b1;
    tick();
    start8 = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      ready8 = pat[i % 4];
      start8 = (i == 5);
      if (i == 5) for (int k = 0; k < 8; k++) din8[k*32 +: 32] = 32'hBAD0_0000 + 32'(k);
      tick();
      if (done8) done_cnt++;
    end
    start8 = 1'b0;
    chk("bp_stream_done_count", done_cnt, 1);
    chk("bp_stream_q_empty", q8.size(), 0);
    chk("bp_stream_busy", busy8, 0);

    // NCH=5: out-of-range direct select
    for (int k = 0; k < 5; k++) din5[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
    mode5 = 1'b0; sel5 = 3'd6; ready5 = 1'b1;
    tick();
    chk("odd_err", err5, 1);
    chk("odd_err_valid", valid5, 0);
    sel5 = 3'd4;
    push5(32'hC0DE_0004, 4);
    tick();
    chk("odd_err_pulse", err5, 0);
    chk("odd_valid_sel4", valid5, 1);
    mode5 = 1'b1; start5 = 1'b0;
    tick();

    // NCH=5: reset while idx 2 is presented
    push5(32'hC0DE_0000, 0);
    push5(32'hC0DE_0001, 1);
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    tick(); tick(); tick();
    chk("abort_idx_before", idx5, 2);
    chk("abort_busy_before", busy5, 1);
    rst5 = 1'b0; ready5 = 1'b0;
    tick();
    chk("abort_outputs", {valid5, dout5, idx5, busy5, done5, err5}, 64'd0);
    tick();
    chk("abort_no_done", done5, 0);
    chk("abort_q_empty", q5.size(), 0);

    // NCH=5: restart streams idx 0..4 again
    rst5 = 1'b1; ready5 = 1'b1; start5 = 1'b1;
    for (int k = 0; k < 5; k++) push5(32'hC0DE_0000 + 32'(k), k);
    tick();
    start5 = 1'b0;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (done5) break;
    end
    chk("restart_done_cycle", n, 6);
    chk("restart_q_empty", q5.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
